// File: rtl/key_event_queue.sv
// Turns debounced key levels into press/release/auto-repeat events and queues
// them in a 4-deep FIFO behind a valid/ready port.
module key_event_queue #(
  parameter logic [23:0] HOLD_CYC   = 24'd1_000_000,
  parameter logic [23:0] REPEAT_CYC = 24'd250_000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] press,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [1:0] ev_key,
  output logic [1:0] ev_type,
  output logic       overflow
);

  localparam logic [23:0] HOLD_LAST   = HOLD_CYC - 24'd1;
  localparam logic [23:0] REPEAT_LOAD = HOLD_CYC - REPEAT_CYC;
  localparam logic [1:0]  TYPE_PRESS   = 2'b00;
  localparam logic [1:0]  TYPE_RELEASE = 2'b01;
  localparam logic [1:0]  TYPE_REPEAT  = 2'b10;

  logic [3:0]  press_q;
  logic [3:0]  rise_s;
  logic [3:0]  fall_s;
  logic [3:0]  rep_s;
  logic [23:0] hold_q [4];
  logic [23:0] hold_d [4];

  // Bit order is arbitration priority: [3:0] press, [7:4] repeat, [11:8] release.
  logic [11:0] pend_q;
  logic [11:0] pend_d;
  logic [11:0] ev_s;
  logic [11:0] grant_s;
  logic        drop_s;
  logic        found_s;
  logic [3:0]  sel_s;
  logic [1:0]  sel_type_s;

  logic        push_s;
  logic        pop_s;
  logic [3:0]  mem_q [4];
  logic [1:0]  wr_q;
  logic [1:0]  rd_q;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic        overflow_q;

  assign rise_s = press & ~press_q;
  assign fall_s = ~press & press_q;

  // Per-key hold counters; reaching the last hold cycle emits a repeat and
  // rewinds so later repeats come REPEAT_CYC apart.
  always_comb begin
    rep_s = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      hold_d[k] = hold_q[k];
      if (!press[k] || rise_s[k]) begin
        hold_d[k] = 24'd0;
      end else if (hold_q[k] == HOLD_LAST) begin
        rep_s[k]  = 1'b1;
        hold_d[k] = REPEAT_LOAD;
      end else begin
        hold_d[k] = hold_q[k] + 24'd1;
      end
    end
  end

  // Fixed-priority pick of the lowest set pending flag.
  always_comb begin
    sel_s = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      sel_s = pend_q[i] ? 4'(i) : sel_s;
    end
    found_s = |pend_q;
    push_s  = found_s & ~cnt_q[2];
    grant_s = push_s ? (12'b1 << sel_s) : 12'b0;
  end

  // Map the selected flag group back to its event type code.
  always_comb begin
    case (sel_s[3:2])
      2'd0:    sel_type_s = TYPE_PRESS;
      2'd1:    sel_type_s = TYPE_REPEAT;
      2'd2:    sel_type_s = TYPE_RELEASE;
      default: sel_type_s = TYPE_PRESS;
    endcase
  end

  // Pending-flag update: an event hitting an already-set flag is lost, even if
  // that flag is being granted this cycle; a release kills a stale repeat.
  always_comb begin
    ev_s   = {fall_s, rep_s, rise_s};
    drop_s = |(ev_s & pend_q);
    pend_d = (pend_q & ~grant_s) | (ev_s & ~pend_q);
    pend_d[7:4] = pend_d[7:4] & ~fall_s;
  end

  assign pop_s = (cnt_q != 3'd0) & ev_ready;

  // FIFO occupancy.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Edge detect, hold counters, pending flags and sticky overflow.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      press_q    <= 4'b0000;
      pend_q     <= 12'b0;
      overflow_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        hold_q[k] <= 24'd0;
      end
    end else begin
      press_q    <= press;
      pend_q     <= pend_d;
      overflow_q <= overflow_q | drop_s;
      for (int k = 0; k < 4; k++) begin
        hold_q[k] <= hold_d[k];
      end
    end
  end

  // Event FIFO storage and pointers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      cnt_q <= 3'd0;
      for (int e = 0; e < 4; e++) begin
        mem_q[e] <= 4'h0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push_s) begin
        mem_q[wr_q] <= {sel_s[1:0], sel_type_s};
        wr_q        <= wr_q + 2'd1;
      end
      if (pop_s) begin
        rd_q <= rd_q + 2'd1;
      end
    end
  end

  assign ev_valid = (cnt_q != 3'd0);
  assign ev_key   = mem_q[rd_q][3:2];
  assign ev_type  = mem_q[rd_q][1:0];
  assign overflow = overflow_q;

endmodule
